gpio_in_debounce: RTL and testbench

//  Pad-side input conditioner between raw GPIO pad inputs and the core-side buffer/inverter cells.
//  Per bit: 2-flop synchroniser, stability counter, debounced level, one-cycle rise/fall pulses.

---
 rtl/gpio_in_debounce.sv | 100 ++++++++++
 tb/tb_gpio_in_debounce.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioner: 2-flop sync, per-bit stability counter, debounced level, edge pulses.
// Define GPIO_IRQ_LATCH_EN to get sticky W1C irq_status and a registered irq.
module gpio_in_debounce_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s2,
    input  logic             enable,
    input  logic [CNT_W-1:0] n,
    output logic             level,
    output logic             rise,
    output logic             fall
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!enable || s2 == level) begin
                cnt <= '0;
            end else if (cnt >= n) begin
                // live threshold: a lowered N commits immediately if cnt already reached it
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
                fall  <= ~s2;
            end else if (cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module gpio_in_debounce #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_in,
    input  logic             enable,
    input  logic [CNT_W-1:0] debounce_cycles,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);
    logic [WIDTH-1:0] s1, s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pad_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_in_debounce_lane #(.CNT_W(CNT_W)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .s2     (s2[i]),
            .enable (enable),
            .n      (debounce_cycles),
            .level  (level_out[i]),
            .rise   (rise_pulse[i]),
            .fall   (fall_pulse[i])
        );
    end

`ifdef GPIO_IRQ_LATCH_EN
    // set term is OR'd after the clear so a fresh edge beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clear) | ((rise_pulse | fall_pulse) & irq_mask);
            irq        <= |irq_status;
        end
    end
`else
    logic unused_irq_clear;
    assign unused_irq_clear = ^irq_clear;
    assign irq_status       = '0;
    assign irq              = |((rise_pulse | fall_pulse) & irq_mask);
`endif
endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce; sticky-irq scenario runs when GPIO_IRQ_LATCH_EN is defined.
module tb_gpio_in_debounce;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pad_in;
    logic       enable;
    logic [7:0] debounce_cycles;
    logic [3:0] irq_mask;
    logic [3:0] irq_clear;
    logic [3:0] level_out, rise_pulse, fall_pulse, irq_status;
    logic       irq;
    int         tests = 0;
    int         fails = 0;

    gpio_in_debounce #(.WIDTH(4), .CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .pad_in          (pad_in),
        .enable          (enable),
        .debounce_cycles (debounce_cycles),
        .irq_mask        (irq_mask),
        .irq_clear       (irq_clear),
        .level_out       (level_out),
        .rise_pulse      (rise_pulse),
        .fall_pulse      (fall_pulse),
        .irq_status      (irq_status),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        pad_in    = '0;
        irq_clear = '0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pad_in = 4'b1111; enable = 1'b1; debounce_cycles = 8'd0;
        irq_mask = 4'b1111; irq_clear = '0;
        tick(2);
        tests++;
        if ({level_out, rise_pulse, fall_pulse, irq_status, irq} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%b want=0", {level_out, rise_pulse, fall_pulse, irq_status, irq});
        end
        reset = 1'b0; pad_in = '0;
        tick(4);
    endtask

    task automatic test_latency_n4();
        do_reset();
        debounce_cycles = 8'd4; irq_mask = 4'b0001;
        pad_in = 4'b0001;
        tick(6);
        tests++;
        if (level_out !== 4'b0000 || rise_pulse !== 4'b0000) begin
            fails++;
            $display("FAIL n4_early level=%b rise=%b want 0000/0000", level_out, rise_pulse);
        end
        tick();
        tests++;
        if (level_out !== 4'b0001 || rise_pulse !== 4'b0001) begin
            fails++;
            $display("FAIL n4_edge7 level=%b rise=%b want 0001/0001", level_out, rise_pulse);
        end
`ifndef GPIO_IRQ_LATCH_EN
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL comb_irq_pulse got=%b want=1", irq);
        end
`endif
        tick();
        tests++;
        if (level_out !== 4'b0001 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
            fails++;
            $display("FAIL n4_one_cycle level=%b rise=%b fall=%b want 0001/0000/0000", level_out, rise_pulse, fall_pulse);
        end
`ifndef GPIO_IRQ_LATCH_EN
        tests++;
        if (irq !== 1'b0 || irq_status !== 4'b0000) begin
            fails++;
            $display("FAIL comb_irq_drop irq=%b status=%b want 0/0000", irq, irq_status);
        end
`endif
    endtask

    task automatic test_glitch_reject();
        logic [3:0] seen;
        do_reset();
        debounce_cycles = 8'd4;
        seen = '0;
        pad_in = 4'b0010;
        tick(3);
        pad_in = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= rise_pulse | fall_pulse | level_out;
        end
        tests++;
        if (seen !== 4'b0000) begin
            fails++;
            $display("FAIL glitch_reject seen=%b want 0000", seen);
        end
        // counter restarted from 0: a fresh stable high takes the full N+3
        pad_in = 4'b0010;
        tick(6);
        tests++;
        if (level_out !== 4'b0000) begin
            fails++;
            $display("FAIL glitch_restart_early level=%b want 0000", level_out);
        end
        tick();
        tests++;
        if (level_out !== 4'b0010 || rise_pulse !== 4'b0010) begin
            fails++;
            $display("FAIL glitch_restart level=%b rise=%b want 0010/0010", level_out, rise_pulse);
        end
    endtask

    task automatic test_n0_multi();
        do_reset();
        debounce_cycles = 8'd0; irq_mask = 4'b0001;
        pad_in = 4'b1010;
        tick(2);
        tests++;
        if (level_out !== 4'b0000) begin
            fails++;
            $display("FAIL n0_early level=%b want 0000", level_out);
        end
        tick();
        tests++;
        if (level_out !== 4'b1010 || rise_pulse !== 4'b1010 || fall_pulse !== 4'b0000) begin
            fails++;
            $display("FAIL n0_rise level=%b rise=%b fall=%b want 1010/1010/0000", level_out, rise_pulse, fall_pulse);
        end
`ifndef GPIO_IRQ_LATCH_EN
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_masked got=%b want=0", irq);
        end
`endif
        tick();
        tests++;
        if (rise_pulse !== 4'b0000) begin
            fails++;
            $display("FAIL n0_rise_once rise=%b want 0000", rise_pulse);
        end
        pad_in = 4'b0000;
        tick(3);
        tests++;
        if (level_out !== 4'b0000 || fall_pulse !== 4'b1010 || rise_pulse !== 4'b0000) begin
            fails++;
            $display("FAIL n0_fall level=%b fall=%b rise=%b want 0000/1010/0000", level_out, fall_pulse, rise_pulse);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        debounce_cycles = 8'd10;
        pad_in = 4'b0001;
        tick(13);
        tests++;
        if (level_out !== 4'b0001) begin
            fails++;
            $display("FAIL n10_latency level=%b want 0001", level_out);
        end
        pad_in = 4'b0101;
        tick(6);
        reset = 1'b1;
        tick();
        tests++;
        if ({level_out, rise_pulse, fall_pulse, irq_status, irq} !== 17'd0) begin
            fails++;
            $display("FAIL mid_reset got=%b want=0", {level_out, rise_pulse, fall_pulse, irq_status, irq});
        end
        reset = 1'b0;
        tick(12);
        tests++;
        if (level_out !== 4'b0000) begin
            fails++;
            $display("FAIL post_reset_early level=%b want 0000", level_out);
        end
        tick();
        tests++;
        if (level_out !== 4'b0101 || rise_pulse !== 4'b0101) begin
            fails++;
            $display("FAIL post_reset_13 level=%b rise=%b want 0101/0101", level_out, rise_pulse);
        end
    endtask

    task automatic test_enable_freeze();
        logic [3:0] seen;
        do_reset();
        debounce_cycles = 8'd5;
        enable = 1'b0;
        pad_in = 4'b1000;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= level_out | rise_pulse | fall_pulse;
        end
        tests++;
        if (seen !== 4'b0000) begin
            fails++;
            $display("FAIL enable_freeze seen=%b want 0000", seen);
        end
        enable = 1'b1;
        tick(5);
        tests++;
        if (level_out !== 4'b0000) begin
            fails++;
            $display("FAIL reenable_early level=%b want 0000", level_out);
        end
        tick();
        tests++;
        if (level_out !== 4'b1000 || rise_pulse !== 4'b1000) begin
            fails++;
            $display("FAIL reenable_6 level=%b rise=%b want 1000/1000", level_out, rise_pulse);
        end
    endtask

    task automatic test_live_n();
        do_reset();
        debounce_cycles = 8'd10;
        pad_in = 4'b0001;
        tick(8);    // cnt has reached 6
        tests++;
        if (level_out !== 4'b0000) begin
            fails++;
            $display("FAIL live_n_before level=%b want 0000", level_out);
        end
        debounce_cycles = 8'd3;
        tick();
        tests++;
        if (level_out !== 4'b0001 || rise_pulse !== 4'b0001) begin
            fails++;
            $display("FAIL live_n_lower level=%b rise=%b want 0001/0001", level_out, rise_pulse);
        end
    endtask

`ifdef GPIO_IRQ_LATCH_EN
    task automatic test_irq_latch();
        do_reset();
        debounce_cycles = 8'd0; irq_mask = 4'b0001;
        pad_in = 4'b0011;
        tick(3);    // rise on bits 0,1; bit1 masked
        tick();
        tests++;
        if (irq_status !== 4'b0001 || irq !== 1'b0) begin
            fails++;
            $display("FAIL latch_set status=%b irq=%b want 0001/0", irq_status, irq);
        end
        tick();
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL latch_irq got=%b want=1", irq);
        end
        pad_in = 4'b0010;
        tick(3);    // fall on bit0 visible now
        irq_clear = 4'b0001;
        tick();
        irq_clear = 4'b0000;
        tests++;
        if (irq_status !== 4'b0001) begin
            fails++;
            $display("FAIL clear_vs_edge status=%b want 0001", irq_status);
        end
        tick(2);
        irq_clear = 4'b0001;
        tick();
        irq_clear = 4'b0000;
        tests++;
        if (irq_status !== 4'b0000) begin
            fails++;
            $display("FAIL clear status=%b want 0000", irq_status);
        end
        tick();
        tests++;
        if (irq !== 1'b0) begin
            fails++;
            $display("FAIL clear_irq got=%b want=0", irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency_n4();
        test_glitch_reject();
        test_n0_multi();
        test_mid_reset();
        test_enable_freeze();
        test_live_n();
`ifdef GPIO_IRQ_LATCH_EN
        test_irq_latch();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
